// File: rtl/ippcsge_carr_sense_mc.sv
// Multi-channel carrier-sense, collision and IFG deference engine (TX clock domain).
// Optional per-channel saturating collision counters are built when CARR_STATS_EN is defined.
module ippcsge_carr_sense_mc #(
  parameter int NCH      = 4,
  parameter int SYNC     = 2,
  parameter int IFG_CYC  = 12,
  parameter int COL_HOLD = 4,
  parameter int CNTW     = 16
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NCH-1:0]    rep_mode,
  input  logic [NCH-1:0]    fdx_mode,
  input  logic [NCH-1:0]    transmitting,
  input  logic [NCH-1:0]    receiving,
  output logic [NCH-1:0]    crs,
  output logic [NCH-1:0]    col,
  output logic [NCH-1:0]    defer
`ifdef CARR_STATS_EN
  ,
  output logic [NCH*CNTW-1:0] col_cnt,
  input  logic [NCH-1:0]      col_cnt_clr
`endif
);

  localparam int MAXV = (IFG_CYC > COL_HOLD) ? IFG_CYC : COL_HOLD;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0] IFG_LOAD = (IFG_CYC > 0) ? CW'(IFG_CYC - 1) : '0;
  localparam logic [CW-1:0] COL_LOAD = CW'(COL_HOLD - 1);

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_ON  = 2'd1;
  localparam logic [1:0] ST_IFG = 2'd2;

  if (NCH < 1 || NCH > 16 || SYNC < 1 || SYNC > 4 || IFG_CYC < 0 || IFG_CYC > 255 ||
      COL_HOLD < 1 || COL_HOLD > 255 || CNTW < 1) begin : g_bad_param
    $error("ippcsge_carr_sense_mc: parameter out of range");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC-1:0] sync_q, sync_d;
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   ifg_q, ifg_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic            crs_q, crs_d;
    logic            col_q, col_d;
    logic            defer_q, defer_d;
    logic            srx, creq, creq_col;

    always_comb begin
      sync_d   = SYNC'({sync_q, receiving[i]});
      srx      = sync_q[SYNC-1];
      creq     = (~rep_mode[i] & transmitting[i]) | srx;
      creq_col = ~fdx_mode[i] & ~rep_mode[i] & transmitting[i] & srx;

      state_d = state_q;
      ifg_d   = ifg_q;
      case (state_q)
        ST_OFF: begin
          if (creq) state_d = ST_ON;
        end
        ST_ON: begin
          if (!creq) begin
            if (IFG_CYC > 0) begin
              state_d = ST_IFG;
              ifg_d   = IFG_LOAD;
            end else begin
              state_d = ST_OFF;
            end
          end
        end
        ST_IFG: begin
          if (creq) begin
            state_d = ST_ON;
            ifg_d   = '0;
          end else if (ifg_q == '0) begin
            state_d = ST_OFF;
          end else begin
            ifg_d = ifg_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          ifg_d   = '0;
        end
      endcase

      // Hold counter runs down from the rising edge regardless of creq_col;
      // creq_col only keeps col up once the minimum time has elapsed.
      col_d  = col_q;
      hold_d = hold_q;
      if (fdx_mode[i]) begin
        col_d  = 1'b0;
        hold_d = '0;
      end else if (!col_q) begin
        if (creq_col) begin
          col_d  = 1'b1;
          hold_d = COL_LOAD;
        end
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if (!creq_col) begin
        col_d = 1'b0;
      end

      crs_d   = (state_d == ST_ON);
      defer_d = (state_d != ST_OFF) & ~fdx_mode[i];
    end

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        sync_q  <= '0;
        state_q <= ST_OFF;
        ifg_q   <= '0;
        hold_q  <= '0;
        crs_q   <= 1'b0;
        col_q   <= 1'b0;
        defer_q <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        ifg_q   <= ifg_d;
        hold_q  <= hold_d;
        crs_q   <= crs_d;
        col_q   <= col_d;
        defer_q <= defer_d;
      end
    end

    assign crs[i]   = crs_q;
    assign col[i]   = col_q;
    assign defer[i] = defer_q;

`ifdef CARR_STATS_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Counts col rising edges; a clear request beats a coincident increment.
    always_comb begin
      cnt_d = cnt_q;
      if (col_cnt_clr[i]) begin
        cnt_d = '0;
      end else if (col_d && !col_q && (cnt_q != {CNTW{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign col_cnt[i*CNTW +: CNTW] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_ippcsge_carr_sense_mc.sv
// Self-checking bench for ippcsge_carr_sense_mc: directed scenarios plus random traffic,
// every cycle compared against a cycle-count based behavioural model.
module tb_ippcsge_carr_sense_mc;

  localparam int NCH      = 4;
  localparam int SYNC     = 2;
  localparam int IFG_CYC  = 12;
  localparam int COL_HOLD = 4;
`ifdef CARR_STATS_EN
  localparam int CNTW = 2;
`else
  localparam int CNTW = 16;
`endif

  logic           clk = 1'b0;
  logic           rst_;
  logic [NCH-1:0] repMode, fdxMode, transmitting, receiving;
  logic [NCH-1:0] crs, col, defer;
`ifdef CARR_STATS_EN
  logic [NCH*CNTW-1:0] colCnt;
  logic [NCH-1:0]      colCntClr;
`endif

  always #5 clk = ~clk;

  ippcsge_carr_sense_mc #(
    .NCH(NCH), .SYNC(SYNC), .IFG_CYC(IFG_CYC), .COL_HOLD(COL_HOLD), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .rep_mode(repMode),
    .fdx_mode(fdxMode),
    .transmitting(transmitting),
    .receiving(receiving),
    .crs(crs),
    .col(col),
    .defer(defer)
`ifdef CARR_STATS_EN
    ,
    .col_cnt(colCnt),
    .col_cnt_clr(colCntClr)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: receive history queue, carrier on flag, remaining deference cycles,
  // and absolute cycle at which col may drop.
  bit [NCH-1:0] rxq[$];
  bit mOn[NCH];
  int mTail[NCH];
  bit mDefer[NCH];
  bit mCol[NCH];
  int mColUntil[NCH];
  int mCnt[NCH];

  // Run-length bookkeeping on the DUT outputs, used by the literal checks.
  int crsRun[NCH], lastCrsLen[NCH], tailRun[NCH], lastTail[NCH];
  int colRun[NCH], lastColLen[NCH], crsRises[NCH], riseCyc[NCH];
  int colRises[NCH], crsHigh[NCH], deferHigh[NCH];
  bit prevCrs[NCH], prevCol[NCH];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): actual=%0d expected=%0d", name, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    rxq.delete();
    for (int s = 0; s < SYNC; s++) rxq.push_back('0);
    for (int ch = 0; ch < NCH; ch++) begin
      mOn[ch] = 0; mTail[ch] = 0; mDefer[ch] = 0;
      mCol[ch] = 0; mColUntil[ch] = 0; mCnt[ch] = 0;
    end
  endtask

  task automatic modelStep();
    bit [NCH-1:0] srxV;
    srxV = rxq.pop_front();
    rxq.push_back(receiving);
    for (int ch = 0; ch < NCH; ch++) begin
      bit creq, cc, wasCol;
      creq   = (!repMode[ch] && transmitting[ch]) || srxV[ch];
      cc     = !fdxMode[ch] && !repMode[ch] && transmitting[ch] && srxV[ch];
      wasCol = mCol[ch];
      if (creq) begin
        mOn[ch] = 1; mTail[ch] = 0;
      end else if (mOn[ch]) begin
        mOn[ch] = 0; mTail[ch] = IFG_CYC;
      end else if (mTail[ch] > 0) begin
        mTail[ch]--;
      end
      mDefer[ch] = (mOn[ch] || mTail[ch] > 0) && !fdxMode[ch];
      if (fdxMode[ch]) begin
        mCol[ch] = 0;
      end else if (!mCol[ch]) begin
        if (cc) begin
          mCol[ch] = 1; mColUntil[ch] = cyc + COL_HOLD;
        end
      end else if (cyc >= mColUntil[ch] && !cc) begin
        mCol[ch] = 0;
      end
`ifdef CARR_STATS_EN
      if (colCntClr[ch]) mCnt[ch] = 0;
      else if (mCol[ch] && !wasCol && mCnt[ch] < (1 << CNTW) - 1) mCnt[ch]++;
`else
      if (wasCol && !mCol[ch]) mCnt[ch] = 0;
`endif
    end
  endtask

  task automatic compareAll();
    logic [NCH-1:0] expCrs, expCol, expDefer;
    for (int ch = 0; ch < NCH; ch++) begin
      expCrs[ch] = mOn[ch]; expCol[ch] = mCol[ch]; expDefer[ch] = mDefer[ch];
    end
    checkOutput("crs", crs, expCrs);
    checkOutput("col", col, expCol);
    checkOutput("defer", defer, expDefer);
`ifdef CARR_STATS_EN
    for (int ch = 0; ch < NCH; ch++)
      checkOutput($sformatf("col_cnt[%0d]", ch), colCnt[ch*CNTW +: CNTW], mCnt[ch]);
`endif
  endtask

  task automatic trackRuns();
    for (int ch = 0; ch < NCH; ch++) begin
      if (crs[ch]) begin
        crsRun[ch]++; crsHigh[ch]++;
        if (!prevCrs[ch]) begin crsRises[ch]++; riseCyc[ch] = cyc; end
      end else if (crsRun[ch] > 0) begin
        lastCrsLen[ch] = crsRun[ch]; crsRun[ch] = 0;
      end
      if (!crs[ch] && defer[ch]) tailRun[ch]++;
      else if (tailRun[ch] > 0) begin lastTail[ch] = tailRun[ch]; tailRun[ch] = 0; end
      if (defer[ch]) deferHigh[ch]++;
      if (col[ch]) begin
        colRun[ch]++;
        if (!prevCol[ch]) colRises[ch]++;
      end else if (colRun[ch] > 0) begin
        lastColLen[ch] = colRun[ch]; colRun[ch] = 0;
      end
      prevCrs[ch] = crs[ch]; prevCol[ch] = col[ch];
    end
  endtask

  // Compare process: advance the model on each rising edge, check 1 ns later.
  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_) modelReset();
      else modelStep();
      #1;
      compareAll();
      trackRuns();
    end
  end

  task automatic applyStimulus(input logic [NCH-1:0] rep, input logic [NCH-1:0] fdx,
                               input logic [NCH-1:0] tx, input logic [NCH-1:0] rx, input int n);
    repMode = rep; fdxMode = fdx; transmitting = tx; receiving = rx;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int startCyc, base0, base1;
    rst_ = 1'b0; repMode = '0; fdxMode = '0; transmitting = '0; receiving = '0;
`ifdef CARR_STATS_EN
    colCntClr = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset crs", crs, 0);
    checkOutput("reset col", col, 0);
    checkOutput("reset defer", defer, 0);
    rst_ = 1'b1;
    applyStimulus('0, '0, '0, '0, 3);

    startCyc = cyc;
    applyStimulus('0, '0, 4'b0001, '0, 10);
    applyStimulus('0, '0, '0, '0, 20);
    checkOutput("ch0 tx->crs latency", riseCyc[0] - startCyc, 1);
    checkOutput("ch0 crs length", lastCrsLen[0], 10);
    checkOutput("ch0 defer tail", lastTail[0], 12);

    startCyc = cyc;
    applyStimulus('0, '0, '0, 4'b0010, 5);
    applyStimulus('0, '0, '0, '0, 20);
    checkOutput("ch1 rx->crs latency", riseCyc[1] - startCyc, 3);
    checkOutput("ch1 crs length", lastCrsLen[1], 5);
    checkOutput("ch1 defer tail", lastTail[1], 12);

    base0 = crsRises[2];
    applyStimulus('0, '0, '0, 4'b0100, 3);
    applyStimulus('0, '0, '0, '0, 5);
    applyStimulus('0, '0, '0, 4'b0100, 3);
    applyStimulus('0, '0, '0, '0, 20);
    checkOutput("ch2 crs rises", crsRises[2] - base0, 2);
    checkOutput("ch2 crs length", lastCrsLen[2], 3);
    checkOutput("ch2 defer tail", lastTail[2], 12);

    applyStimulus('0, '0, 4'b1000, 4'b1000, 1);
    applyStimulus('0, '0, 4'b1000, '0, 5);
    applyStimulus('0, '0, '0, '0, 20);
    checkOutput("ch3 col overlap1", lastColLen[3], 4);

    applyStimulus('0, '0, 4'b1000, 4'b1000, 7);
    applyStimulus('0, '0, 4'b1000, '0, 5);
    applyStimulus('0, '0, '0, '0, 20);
    checkOutput("ch3 col overlap7", lastColLen[3], 7);

    base0 = colRises[3]; base1 = deferHigh[3];
    applyStimulus('0, 4'b1000, 4'b1000, 4'b1000, 6);
    applyStimulus('0, 4'b1000, '0, '0, 20);
    checkOutput("ch3 fdx col rises", colRises[3] - base0, 0);
    checkOutput("ch3 fdx defer cycles", deferHigh[3] - base1, 0);
    checkOutput("ch3 fdx crs length", lastCrsLen[3], 8);
    applyStimulus('0, '0, '0, '0, 5);

    base0 = crsHigh[0]; base1 = colRises[0];
    applyStimulus(4'b0001, '0, 4'b0001, '0, 8);
    applyStimulus(4'b0001, '0, '0, '0, 3);
    checkOutput("ch0 rep crs cycles", crsHigh[0] - base0, 0);
    checkOutput("ch0 rep col rises", colRises[0] - base1, 0);
    applyStimulus('0, '0, '0, '0, 3);

    applyStimulus('0, '0, 4'b0001, '0, 3);
    applyStimulus('0, '0, '0, '0, 4);
    checkOutput("ch0 defer in IFG", defer[0], 1);
    rst_ = 1'b0;
    #1;
    checkOutput("async reset crs", crs, 0);
    checkOutput("async reset col", col, 0);
    checkOutput("async reset defer", defer, 0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    applyStimulus('0, '0, '0, '0, 5);
    checkOutput("post-reset defer", defer, 0);
    checkOutput("post-reset crs", crs, 0);

`ifdef CARR_STATS_EN
    for (int k = 0; k < 5; k++) begin
      applyStimulus('0, '0, 4'b0001, 4'b0001, 1);
      applyStimulus('0, '0, 4'b0001, '0, 2);
      applyStimulus('0, '0, '0, '0, 8);
    end
    checkOutput("ch0 col_cnt saturated", colCnt[CNTW-1:0], 3);
    applyStimulus('0, '0, 4'b0001, 4'b0001, 1);
    applyStimulus('0, '0, 4'b0001, '0, 1);
    colCntClr = 4'b0001;
    applyStimulus('0, '0, 4'b0001, '0, 1);
    colCntClr = '0;
    applyStimulus('0, '0, '0, '0, 10);
    checkOutput("ch0 col_cnt clear wins", colCnt[CNTW-1:0], 0);
`endif

    for (int n = 0; n < 400; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(7) == 0) transmitting[ch] = ~transmitting[ch];
        if ($urandom_range(7) == 0) receiving[ch] = ~receiving[ch];
        if ($urandom_range(63) == 0) fdxMode[ch] = ~fdxMode[ch];
        if ($urandom_range(95) == 0) repMode[ch] = ~repMode[ch];
`ifdef CARR_STATS_EN
        colCntClr[ch] = ($urandom_range(31) == 0);
`endif
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
